vga_sync: RTL
=============

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 The block SHALL run on one clock, clk; reset is asynchronous and active-low, port name reset.
REQ-002 Parameter CLK_DIV, default 2, meaning system clocks per pixel (legal 1..4).
REQ-003 Parameters H_DISPLAY 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal visible, front porch, sync and back porch widths in pixels.
REQ-004 Parameters V_DISPLAY 480, V_FP 10, V_SYNC 2, V_BP 33: vertical visible, front porch, sync and back porch widths in lines.
REQ-005 Port clk, input, 1 bit: system clock, 50 MHz nominal.
REQ-006 Port reset, input, 1 bit: asynchronous active-low reset.
REQ-007 Port x, output, 10 bits: current pixel column, 0..H_TOTAL-1.
REQ-008 Port y, output, 10 bits: current line, 0..V_TOTAL-1.
REQ-009 Port hsync, output, 1 bit: horizontal sync, active-low, registered.
REQ-010 Port vsync, output, 1 bit: vertical sync, active-low, registered.
REQ-011 Port video_on, output, 1 bit: high while (x,y) is in the visible area.
REQ-012 Port p_tick, output, 1 bit: one-clk pulse marking the cycle in which the counters advance.
REQ-013 Port frame_tick, output, 1 bit: one-clk pulse on the last pixel of each frame.

Function
REQ-014 H_TOTAL SHALL be H_DISPLAY+H_FP+H_SYNC+H_BP (800); V_TOTAL SHALL be V_DISPLAY+V_FP+V_SYNC+V_BP (525).
REQ-015 A divider counter SHALL count 0..CLK_DIV-1 and wrap; p_tick SHALL be high only while the divider equals CLK_DIV-1 (CLK_DIV=1: p_tick constantly high).
REQ-016 On a clk edge with p_tick high: x SHALL increment; when x = H_TOTAL-1 it SHALL wrap to 0 and y SHALL increment.
REQ-017 When x wraps with y = V_TOTAL-1, y SHALL wrap to 0 in the same edge.
REQ-018 x and y SHALL hold on clk edges with p_tick low.
REQ-019 hsync SHALL be 0 exactly while x is in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1] = [656,751], computed from next-state counters so it changes on the same edge as x.
REQ-020 vsync SHALL be 0 exactly while y is in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1] = [490,491], aligned with y the same way.
REQ-021 video_on SHALL be combinational: (x < H_DISPLAY) and (y < V_DISPLAY).
REQ-022 frame_tick SHALL equal p_tick AND x = H_TOTAL-1 AND y = V_TOTAL-1.
REQ-023 The pair (x=0, y=V_DISPLAY+1 = 481) SHALL occur for exactly one pixel period per frame; downstream game logic uses it as its refresh tick.
REQ-024 All comparisons SHALL be unsigned 10-bit; counters SHALL never exceed H_TOTAL-1 / V_TOTAL-1.

Reset
REQ-025 While reset is low: divider 0, x 0, y 0, hsync 1, vsync 1, p_tick 0 (CLK_DIV>1), frame_tick 0; video_on consequently 1.
REQ-026 Reset assertion mid-line or mid-frame SHALL return all state to REQ-025 values immediately, without waiting for a clock.
REQ-027 After reset release, the first p_tick SHALL occur CLK_DIV clk edges later (edge 2 for default).

Structure
REQ-028 Timing constants (H_/V_ widths, totals, sync start/end) SHALL live in shared package vga_timing_pkg, also used by the pixel-drawing blocks.
REQ-029 The divider SHALL be a sub-module pixel_tick_gen (parameter CLK_DIV, outputs p_tick); counters and sync logic stay in vga_sync.

Verification
REQ-030 Hold reset low 5 clks, release -> x=0, y=0, hsync=1, vsync=1; p_tick first high on 2nd clk after release, then every 2nd clk.
REQ-031 Run one line -> hsync falls when x becomes 656, rises when x becomes 752; x wraps 799->0 and y 0->1 on the 800th p_tick.
REQ-032 Run one full frame -> vsync low for exactly 2 lines (y=490,491, 1600 p_ticks); frame_tick single pulse at x=799,y=524; frame = 420000 p_ticks = 840000 clks.
REQ-033 Check video_on over a frame -> high for exactly 307200 p_ticks; (x=0,y=481) seen exactly once.
REQ-034 Assert reset at x=300,y=200 between clk edges -> outputs reach REQ-025 values before next edge; restart matches REQ-030.
REQ-035 Rebuild with CLK_DIV=1 -> p_tick constant 1, frame = 420000 clks, sync positions unchanged in pixel terms.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and helpers for vga_sync and the pixel-drawing blocks.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int unsigned VGA_H_DISPLAY    = 640;
    localparam int unsigned VGA_H_FP         = 16;
    localparam int unsigned VGA_H_SYNC       = 96;
    localparam int unsigned VGA_H_BP         = 48;
    localparam int unsigned VGA_H_TOTAL      = VGA_H_DISPLAY + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FP;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;

    localparam int unsigned VGA_V_DISPLAY    = 480;
    localparam int unsigned VGA_V_FP         = 10;
    localparam int unsigned VGA_V_SYNC       = 2;
    localparam int unsigned VGA_V_BP         = 33;
    localparam int unsigned VGA_V_TOTAL      = VGA_V_DISPLAY + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FP;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    // Inclusive unsigned range test shared by the sync decoders.
    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate enable: divider counts 0..CLK_DIV-1, p_tick high while it sits at the last value.
module pixel_tick_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

    logic [1:0] div_q;
    logic [1:0] div_d;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 2'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // With CLK_DIV=1 the divider stays at 0, so p_tick is constantly high.
    assign p_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA raster counters with registered active-low syncs aligned to the counter update edge.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP
) (
    input  logic         clk,
    input  logic         reset,
    output logic [9:0]   x,
    output logic [9:0]   y,
    output logic         hsync,
    output logic         vsync,
    output logic         video_on,
    output logic         p_tick,
    output logic         frame_tick
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FP);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FP);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic   tick;
    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .p_tick (tick)
    );

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        // Syncs decode the next-state counters so they flip on the same edge as x/y.
        hsync_d = !in_range(x_d, HS_START, HS_END);
        vsync_d = !in_range(y_d, VS_START, VS_END);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign p_tick     = tick;
    assign video_on   = (x_q < H_VIS) && (y_q < V_VIS);
    assign frame_tick = tick && (x_q == H_LAST) && (y_q == V_LAST);

endmodule
